sram_1r1w_ctrl: RTL and testbench

//  Front-end controller for a 0rw1r1w OpenRAM macro (64b x 512, 8b write mask).

---
 rtl/sram_1r1w_ctrl_pkg.sv | 23 ++
 rtl/sram_1r1w_ctrl_if.sv | 40 ++++
 rtl/sram_1r1w_ctrl_rdata_buf.sv | 58 +++++
 rtl/sram_1r1w_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_1r1w_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1r1w_ctrl_pkg.sv
// Shared types and widths for the 1R1W SRAM front-end controller.
// Holds the controller state type and an address-compare helper.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 9;
    localparam int MASK_W     = DATA_W / 8;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int ADDR_MAX_W = 32;

    function automatic logic addr_hit(
        input logic [ADDR_MAX_W-1:0] a,
        input logic [ADDR_MAX_W-1:0] b
    );
        return a == b;
    endfunction

endpackage

// File: rtl/sram_1r1w_ctrl_if.sv
// Client-side bundle: two write requesters, one read requester
// and the read-data return channel.
interface sram_1r1w_ctrl_if #(
    parameter int AW = sram_ctrl_pkg::ADDR_W,
    parameter int DW = sram_ctrl_pkg::DATA_W,
    parameter int MW = sram_ctrl_pkg::MASK_W
);
    logic          wa_valid;
    logic          wa_ready;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic [MW-1:0] wa_mask;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [MW-1:0] wb_mask;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic          rd_rready;
    logic [DW-1:0] rd_rdata;

    modport master (
        output wa_valid, wa_addr, wa_data, wa_mask,
        output wb_valid, wb_addr, wb_data, wb_mask,
        output rd_valid, rd_addr, rd_rready,
        input  wa_ready, wb_ready, rd_ready,
        input  rd_rvalid, rd_rdata
    );

    modport slave (
        input  wa_valid, wa_addr, wa_data, wa_mask,
        input  wb_valid, wb_addr, wb_data, wb_mask,
        input  rd_valid, rd_addr, rd_rready,
        output wa_ready, wb_ready, rd_ready,
        output rd_rvalid, rd_rdata
    );
endinterface

// File: rtl/sram_1r1w_ctrl_rdata_buf.sv
// Two-entry read-data FIFO; head is presented on o_data.
// o_valid is a flop so the downstream valid is glitch-free.
module sram_rdata_buf #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          r_valid;
    logic          w_pop;
    logic [1:0]    w_count_nxt;

    assign w_pop = i_pop & r_valid;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({i_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_valid  <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Front-end for a 1R1W SRAM macro: zero-fill after reset, round-robin
// write arbitration, same-address read stall and buffered read return.
module sram_1r1w_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int NUM_WMASKS = DATA_WIDTH / 8,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_1r1w_ctrl_if.slave       bus,
    output logic                  init_done,
    output logic                  csb0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_last_b;
    logic                  r_inflight;
    logic                  w_run;
    logic                  w_init_wr;
    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_gnt;
    logic                  w_hazard;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NUM_WMASKS-1:0] w_wmask;
    logic [1:0]            w_count;
    logic [1:0]            w_occ;
    logic                  w_rvalid;
    logic [DATA_WIDTH-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    // rst_n gates the fill write so the macro port idles during reset
    always_comb begin
        w_state_nxt = r_state;
        w_init_wr   = 1'b0;
        unique case (r_state)
            INIT: begin
                w_init_wr = INIT_ZERO & rst_n;
                if (!INIT_ZERO || r_init_cnt == LAST_ADDR)
                    w_state_nxt = RUN;
            end
            RUN: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_init_cnt <= '0;
        else if (r_state == INIT)
            r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
    end

    assign w_run   = (r_state == RUN);
    assign w_gnt_a = w_run & bus.wa_valid & (~bus.wb_valid | r_last_b);
    assign w_gnt_b = w_run & bus.wb_valid & (~bus.wa_valid | ~r_last_b);
    assign w_gnt   = w_gnt_a | w_gnt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_last_b <= 1'b1;
        else if (w_gnt_a) r_last_b <= 1'b0;
        else if (w_gnt_b) r_last_b <= 1'b1;
    end

    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_wmask = '0;
        unique case (1'b1)
            w_init_wr: begin
                w_waddr = r_init_cnt;
                w_wmask = '1;
            end
            w_gnt_a: begin
                w_waddr = bus.wa_addr;
                w_wdata = bus.wa_data;
                w_wmask = bus.wa_mask;
            end
            w_gnt_b: begin
                w_waddr = bus.wb_addr;
                w_wdata = bus.wb_data;
                w_wmask = bus.wb_mask;
            end
            default: ;
        endcase
    end

    assign w_hazard = w_gnt & addr_hit(ADDR_MAX_W'(w_waddr),
                                       ADDR_MAX_W'(bus.rd_addr));
    assign w_occ    = w_count + {1'b0, r_inflight};

    assign bus.wa_ready = w_gnt_a;
    assign bus.wb_ready = w_gnt_b;
    assign bus.rd_ready = w_run & (w_occ < 2'd2) & ~w_hazard;
    assign w_rd_acc     = bus.rd_valid & bus.rd_ready;

    assign csb0   = ~(w_init_wr | w_gnt);
    assign addr0  = w_waddr;
    assign wmask0 = w_wmask;
    assign din0   = w_wdata;
    assign csb1   = ~w_rd_acc;
    assign addr1  = w_rd_acc ? bus.rd_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_inflight <= 1'b0;
        else        r_inflight <= w_rd_acc;
    end

    sram_rdata_buf #(
        .DW (DATA_WIDTH)
    ) u_rbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (dout1),
        .i_pop   (bus.rd_rready),
        .o_valid (w_rvalid),
        .o_data  (w_rdata),
        .o_count (w_count)
    );

    assign bus.rd_rvalid = w_rvalid;
    assign bus.rd_rdata  = w_rdata;
    assign init_done     = w_run;
endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Bench for sram_1r1w_ctrl with a behavioural 1R1W macro model.
// Macro latches inputs on posedge, writes/reads on the following negedge.
module tb_sram_1r1w_ctrl;
    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        csb0;
    logic [8:0]  addr0;
    logic [7:0]  wmask0;
    logic [63:0] din0;
    logic        csb1;
    logic [8:0]  addr1;
    logic [63:0] dout1;

    int pass_cnt = 0;
    int total    = 0;

    sram_1r1w_ctrl_if bus ();

    sram_1r1w_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .csb0      (csb0),
        .addr0     (addr0),
        .wmask0    (wmask0),
        .din0      (din0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [512];
    logic        m_csb0;
    logic        m_csb1;
    logic [8:0]  m_addr0;
    logic [8:0]  m_addr1;
    logic [7:0]  m_mask;
    logic [63:0] m_din;

    initial begin
        for (int i = 0; i < 512; i++)
            mem[i] = 64'hA5A5_A5A5_0000_0000 | 64'(i);
        dout1 = 64'h0;
    end

    always @(posedge clk) begin
        m_csb0  <= csb0;
        m_csb1  <= csb1;
        m_addr0 <= addr0;
        m_addr1 <= addr1;
        m_mask  <= wmask0;
        m_din   <= din0;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0)
            for (int b = 0; b < 8; b++)
                if (m_mask[b]) mem[m_addr0][8*b +: 8] = m_din[8*b +: 8];
        if (m_csb1 === 1'b0)
            dout1 <= mem[m_addr1];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input bit pb, input logic [8:0] a,
                      input logic [63:0] d, input logic [7:0] m);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (pb) begin
            bus.wb_valid = 1'b1; bus.wb_addr = a;
            bus.wb_data  = d;    bus.wb_mask = m;
        end else begin
            bus.wa_valid = 1'b1; bus.wa_addr = a;
            bus.wa_data  = d;    bus.wa_mask = m;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = pb ? bus.wb_ready : bus.wa_ready;
        end
        @(posedge clk); #1;
        bus.wa_valid = 1'b0;
        bus.wb_valid = 1'b0;
        chk("wr_accept", 64'(got), 64'd1);
    endtask

    task automatic rd(input logic [8:0] a, output logic [63:0] d,
                      output int lat);
        logic acc;
        acc = 1'b0;
        lat = -1;
        d   = '0;
        @(posedge clk); #1;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            acc = bus.rd_ready;
        end
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 8 && lat < 0; k++) begin
                @(negedge clk);
                if (bus.rd_rvalid) begin
                    lat = k;
                    d   = bus.rd_rdata;
                end
            end
        end
    endtask

    typedef struct {
        int          op;
        logic [8:0]  addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [63:0] q[3];
        logic [1:0]  exp_g[4];
        logic [8:0]  exp_a[4];
        int          lat;
        int          bad;
        int          got;
        logic        acc;

        // op 0: write A, 1: write B, 2: read and compare
        tbl.push_back('{2, 9'd0,   64'h0, 8'h00, 64'h0});
        tbl.push_back('{2, 9'd511, 64'h0, 8'h00, 64'h0});
        tbl.push_back('{2, 9'd257, 64'h0, 8'h00, 64'h0});
        tbl.push_back('{2, 9'd20,  64'h0, 8'h00, 64'hA0A0_0000_0000_0020});
        tbl.push_back('{2, 9'd30,  64'h0, 8'h00, 64'hB0B0_0000_0000_0030});
        tbl.push_back('{0, 9'd5,   64'hDEADBEEF_CAFEF00D, 8'h0F, 64'h0});
        tbl.push_back('{2, 9'd5,   64'h0, 8'h00, 64'h00000000_CAFEF00D});
        tbl.push_back('{1, 9'd6,   64'h11223344_55667788, 8'hF0, 64'h0});
        tbl.push_back('{2, 9'd6,   64'h0, 8'h00, 64'h11223344_00000000});
        tbl.push_back('{0, 9'd7,   64'hFFFFFFFF_FFFFFFFF, 8'h81, 64'h0});
        tbl.push_back('{2, 9'd7,   64'h0, 8'h00, 64'hFF000000_000000FF});
        tbl.push_back('{1, 9'd5,   64'h01020304_05060708, 8'hF0, 64'h0});
        tbl.push_back('{2, 9'd5,   64'h0, 8'h00, 64'h01020304_CAFEF00D});
        tbl.push_back('{0, 9'd511, 64'h01234567_89ABCDEF, 8'hFF, 64'h0});
        tbl.push_back('{2, 9'd511, 64'h0, 8'h00, 64'h01234567_89ABCDEF});
        tbl.push_back('{1, 9'd0,   64'hAAAAAAAA_AAAAAAAA, 8'h3C, 64'h0});
        tbl.push_back('{2, 9'd0,   64'h0, 8'h00, 64'h0000AAAA_AAAA0000});

        bus.wa_valid = 0; bus.wa_addr = 0; bus.wa_data = 0; bus.wa_mask = 0;
        bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.wb_mask = 0;
        bus.rd_valid = 0; bus.rd_addr = 0; bus.rd_rready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_csb", {62'd0, csb0, csb1}, 64'd3);
        chk("rst_ready", {61'd0, bus.wa_ready, bus.wb_ready, bus.rd_ready}, 64'd0);
        chk("rst_rvalid", 64'(bus.rd_rvalid), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_addr0", 64'(addr0), 64'd0);
        chk("rst_wmask0", 64'(wmask0), 64'd0);
        chk("rst_din0", din0, 64'd0);

        // zero-fill: requests during INIT must be ignored
        #4 rst_n = 1'b1;
        bus.wa_valid = 1'b1; bus.wa_addr = 9'd3; bus.wa_data = '1;
        bus.wa_mask = '1; bus.rd_valid = 1'b1; bus.rd_addr = 9'd4;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (csb0 !== 1'b0 || addr0 !== 9'(i) || wmask0 !== 8'hFF ||
                din0 !== 64'd0 || init_done !== 1'b0 || csb1 !== 1'b1 ||
                bus.wa_ready !== 1'b0 || bus.rd_ready !== 1'b0)
                bad++;
            if (i == 510) begin
                bus.wa_valid = 1'b0;
                bus.rd_valid = 1'b0;
            end
        end
        chk("init_seq_bad_cycles", 64'(bad), 64'd0);
        @(negedge clk);
        chk("init_done_rise", 64'(init_done), 64'd1);
        chk("init_csb0_idle", 64'(csb0), 64'd1);

        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_a = '{9'd20, 9'd30, 9'd20, 9'd30};
        @(posedge clk); #1;
        bus.wa_valid = 1'b1; bus.wa_addr = 9'd20;
        bus.wa_data  = 64'hA0A0_0000_0000_0020; bus.wa_mask = 8'hFF;
        bus.wb_valid = 1'b1; bus.wb_addr = 9'd30;
        bus.wb_data  = 64'hB0B0_0000_0000_0030; bus.wb_mask = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("arb_grant%0d", c),
                {62'd0, bus.wa_ready, bus.wb_ready}, 64'(exp_g[c]));
            chk($sformatf("arb_addr0_%0d", c), 64'(addr0), 64'(exp_a[c]));
        end
        @(posedge clk); #1;
        bus.wa_valid = 1'b0;
        bus.wb_valid = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].op == 2) begin
                rd(tbl[i].addr, d, lat);
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
                chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd2);
            end else begin
                wr(tbl[i].op == 1, tbl[i].addr, tbl[i].data, tbl[i].mask);
            end
        end

        // same-cycle write and read of one address
        @(posedge clk); #1;
        bus.wa_valid = 1'b1; bus.wa_addr = 9'd9;
        bus.wa_data  = 64'h9999_0000_1234_5678; bus.wa_mask = 8'hFF;
        bus.rd_valid = 1'b1; bus.rd_addr = 9'd9;
        @(negedge clk);
        chk("haz_wr_granted", 64'(bus.wa_ready), 64'd1);
        chk("haz_rd_stalled", 64'(bus.rd_ready), 64'd0);
        chk("haz_csb1_idle", 64'(csb1), 64'd1);
        @(posedge clk); #1;
        bus.wa_valid = 1'b0;
        @(negedge clk);
        chk("haz_rd_next", 64'(bus.rd_ready), 64'd1);
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            @(negedge clk);
            if (bus.rd_rvalid) begin
                got = 1;
                d   = bus.rd_rdata;
            end
        end
        chk("haz_rvalid_seen", 64'(got), 64'd1);
        chk("haz_rdata_new", d, 64'h9999_0000_1234_5678);

        // backpressure: third read stalls, data held, order preserved
        wr(1'b0, 9'd1, 64'h1111_1111_1111_1111, 8'hFF);
        wr(1'b1, 9'd2, 64'h2222_2222_2222_2222, 8'hFF);
        wr(1'b0, 9'd3, 64'h3333_3333_3333_3333, 8'hFF);
        @(posedge clk); #1;
        bus.rd_rready = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 9'd1;
        @(negedge clk);
        chk("bp_acc1", 64'(bus.rd_ready), 64'd1);
        @(posedge clk); #1;
        bus.rd_addr = 9'd2;
        @(negedge clk);
        chk("bp_acc2", 64'(bus.rd_ready), 64'd1);
        @(posedge clk); #1;
        bus.rd_addr = 9'd3;
        @(negedge clk);
        chk("bp_stall3", 64'(bus.rd_ready), 64'd0);
        chk("bp_rvalid", 64'(bus.rd_rvalid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_ready%0d", i), 64'(bus.rd_ready), 64'd0);
            chk($sformatf("bp_hold_data%0d", i), bus.rd_rdata,
                64'h1111_1111_1111_1111);
        end
        @(posedge clk); #1;
        bus.rd_rready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            @(negedge clk);
            if (bus.rd_rvalid) begin
                q[got] = bus.rd_rdata;
                got++;
            end
            acc = bus.rd_valid & bus.rd_ready;
            @(posedge clk); #1;
            if (acc) bus.rd_valid = 1'b0;
        end
        bus.rd_valid = 1'b0;
        chk("bp_count", 64'(got), 64'd3);
        chk("bp_order1", q[0], 64'h1111_1111_1111_1111);
        chk("bp_order2", q[1], 64'h2222_2222_2222_2222);
        chk("bp_order3", q[2], 64'h3333_3333_3333_3333);

        // reset with buffered data and a read being accepted
        @(posedge clk); #1;
        bus.rd_rready = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 9'd5;
        @(negedge clk);
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            @(negedge clk);
            if (bus.rd_rvalid) got = 1;
        end
        @(posedge clk); #1;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 9'd6;
        @(negedge clk);
        chk("r6_pre_rvalid", 64'(bus.rd_rvalid), 64'd1);
        chk("r6_pre_csb1", 64'(csb1), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_async_csb", {62'd0, csb0, csb1}, 64'd3);
        chk("r6_async_rvalid", 64'(bus.rd_rvalid), 64'd0);
        chk("r6_async_init_done", 64'(init_done), 64'd0);
        bus.rd_valid  = 1'b0;
        bus.rd_rready = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("r6_restart_addr0", 64'(addr0), 64'd0);
        chk("r6_restart_csb0", 64'(csb0), 64'd0);
        @(negedge clk);
        chk("r6_restart_addr1", 64'(addr0), 64'd1);

        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_midinit_csb0", 64'(csb0), 64'd1);
        chk("r6_midinit_wmask0", 64'(wmask0), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("r6_reinit_addr0", 64'(addr0), 64'd0);
        chk("r6_reinit_csb0", 64'(csb0), 64'd0);
        for (int i = 0; i < 600 && !init_done; i++) @(negedge clk);
        chk("r6_init_done", 64'(init_done), 64'd1);
        rd(9'd5, d, lat);
        chk("r6_refill_5", d, 64'h0);
        rd(9'd511, d, lat);
        chk("r6_refill_511", d, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
